// File: rtl/jstk_pkg.sv
// rtl/jstk_pkg.sv - shared joystick frame constants, state enum and frame byte helper
package jstk_pkg;

    localparam int JSTK_FRAME_BYTES = 5;
    localparam int JSTK_AXIS_W      = 10;
    localparam int JSTK_BTN_W       = 3;

    localparam logic [2:0] JSTK_B_XLO = 3'd0;
    localparam logic [2:0] JSTK_B_XHI = 3'd1;
    localparam logic [2:0] JSTK_B_YLO = 3'd2;
    localparam logic [2:0] JSTK_B_YHI = 3'd3;
    localparam logic [2:0] JSTK_B_BTN = 3'd4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } jstk_state_e;

    typedef struct packed {
        logic [JSTK_AXIS_W-1:0] x;
        logic [JSTK_AXIS_W-1:0] y;
        logic [JSTK_BTN_W-1:0]  btn;
    } jstk_sample_t;

    // Indices past the last defined byte read as zero so over-reads return 8'h00.
    function automatic logic [7:0] jstk_frame_byte(input jstk_sample_t s, input logic [2:0] idx);
        case (idx)
            JSTK_B_XLO: return s.x[7:0];
            JSTK_B_XHI: return {6'b0, s.x[9:8]};
            JSTK_B_YLO: return s.y[7:0];
            JSTK_B_YHI: return {6'b0, s.y[9:8]};
            JSTK_B_BTN: return {5'b0, s.btn};
            default:    return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_jstk_responder_if.sv
// rtl/spi_jstk_responder_if.sv - SPI link bundle (SCK/CS/MOSI/MISO) with master/slave views
interface spi_jstk_responder_if;

    logic spi_sck;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_sck,
        output spi_cs,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_sck,
        input  spi_cs,
        input  spi_mosi,
        output spi_miso
    );

endinterface

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - multi-stage input synchronizer with rise/fall edge detection
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Reset to 0 so a CS already low when reset drops is not mistaken for a new CS fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_jstk_responder.sv
// rtl/spi_jstk_responder.sv - SPI mode-0 slave returning a joystick frame; err_cnt enabled by SPI_RESP_ERR_CNT_EN
module spi_jstk_responder
    import jstk_pkg::*;
#(
    parameter int FRAME_BYTES = JSTK_FRAME_BYTES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_jstk_responder_if.slave    spi,
    input  logic [JSTK_AXIS_W-1:0] x_val,
    input  logic [JSTK_AXIS_W-1:0] y_val,
    input  logic [JSTK_BTN_W-1:0]  buttons,
    output logic [7:0]             cmd_byte,
    output logic                   cmd_valid,
    output logic [2:0]             byte_idx,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [7:0]             err_cnt
);

    localparam logic [3:0] FRAME_LIMIT = 4'(FRAME_BYTES);

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi.spi_sck),
        .q_o    (sck_s),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi.spi_cs),
        .q_o    (cs_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .d_i    (spi.spi_mosi),
        .q_o    (mosi_s),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_s, cs_s, mosi_rise, mosi_fall};

    jstk_state_e  state_q;
    jstk_sample_t snap_q;
    logic [7:0]   tx_q;
    logic [7:0]   rx_q;
    logic [2:0]   bit_cnt_q;
    logic [2:0]   byte_cnt_q;
    logic         miso_q;
    logic [7:0]   cmd_byte_q;
    logic         cmd_valid_q;
    logic [2:0]   byte_idx_q;
    logic         frame_done_q;
    logic         frame_err_q;

    jstk_sample_t live_s;
    logic [7:0]   first_byte;
    logic [7:0]   next_byte;
    logic [7:0]   rx_next;
    logic [2:0]   byte_cnt_inc;

    assign live_s       = '{x: x_val, y: y_val, btn: buttons};
    assign first_byte   = jstk_frame_byte(live_s, JSTK_B_XLO);
    assign next_byte    = ({1'b0, byte_cnt_q} < FRAME_LIMIT) ? jstk_frame_byte(snap_q, byte_cnt_q) : 8'h00;
    assign rx_next      = {rx_q[6:0], mosi_s};
    assign byte_cnt_inc = (byte_cnt_q == 3'd7) ? 3'd7 : byte_cnt_q + 3'd1;

    // CS rise is checked first so an SCK edge landing in the same synced cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            miso_q       <= 1'b0;
            cmd_byte_q   <= '0;
            cmd_valid_q  <= 1'b0;
            byte_idx_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        snap_q     <= live_s;
                        tx_q       <= first_byte;
                        miso_q     <= first_byte[7];
                        rx_q       <= '0;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        state_q    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                        if (bit_cnt_q != 3'd0) begin
                            frame_err_q <= 1'b1;
                        end else if (byte_cnt_q != 3'd0) begin
                            frame_done_q <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        rx_q <= rx_next;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_byte_q  <= rx_next;
                            cmd_valid_q <= 1'b1;
                            byte_idx_q  <= byte_cnt_q;
                            byte_cnt_q  <= byte_cnt_inc;
                            bit_cnt_q   <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt_q != 3'd0) begin
                            tx_q   <= {tx_q[6:0], 1'b0};
                            miso_q <= tx_q[6];
                        end else begin
                            tx_q   <= next_byte;
                            miso_q <= next_byte[7];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    miso_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_RESP_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (frame_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign spi.spi_miso = miso_q;
    assign cmd_byte     = cmd_byte_q;
    assign cmd_valid    = cmd_valid_q;
    assign byte_idx     = byte_idx_q;
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_jstk_responder.sv
// tb/tb_spi_jstk_responder.sv - self-checking bench: vector table, randomized frames vs reference model, corner sequences
module tb_spi_jstk_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_jstk_responder_if bus ();

    logic [9:0] x_val;
    logic [9:0] y_val;
    logic [2:0] buttons;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic [2:0] byte_idx;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] err_cnt;

    spi_jstk_responder #(.FRAME_BYTES(5), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (bus),
        .x_val      (x_val),
        .y_val      (y_val),
        .buttons    (buttons),
        .cmd_byte   (cmd_byte),
        .cmd_valid  (cmd_valid),
        .byte_idx   (byte_idx),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_errs = 0;

    logic [10:0] cmd_q[$];
    int          done_seen;
    int          err_seen;
    bit          watch_miso;
    bit          miso_hit;

    logic [0:79] mosi_bits;
    logic [0:79] miso_bits;

    always @(negedge clk) begin
        if (cmd_valid) cmd_q.push_back({byte_idx, cmd_byte});
        if (frame_done) done_seen++;
        if (frame_err) err_seen++;
        if (watch_miso && (bus.spi_miso !== 1'b0)) miso_hit = 1'b1;
    end

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_frame();
        cmd_q.delete();
        done_seen = 0;
        err_seen  = 0;
        miso_hit  = 1'b0;
    endtask

    // Mode-0 master: MOSI changes on SCK fall, MISO sampled at SCK rise, half period 8 clk.
    task automatic do_frame(input int nbits);
        miso_bits    = '0;
        bus.spi_cs   = 1'b0;
        bus.spi_mosi = mosi_bits[0];
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            bus.spi_sck  = 1'b1;
            miso_bits[i] = bus.spi_miso;
            wait_clk(8);
            bus.spi_sck = 1'b0;
            if (i + 1 < 80) bus.spi_mosi = mosi_bits[i+1];
            wait_clk(8);
        end
        bus.spi_cs = 1'b1;
        wait_clk(12);
    endtask

    function automatic logic [7:0] model_byte(input logic [9:0] x, input logic [9:0] y,
                                              input logic [2:0] b, input int k);
        logic [39:0] frame;
        frame = {5'b0, b, 6'b0, y[9:8], y[7:0], 6'b0, x[9:8], x[7:0]};
        if (k >= 5) return 8'h00;
        return frame[8*k +: 8];
    endfunction

    function automatic logic [7:0] exp_err_cnt();
`ifdef SPI_RESP_ERR_CNT_EN
        return (exp_errs > 255) ? 8'hFF : 8'(exp_errs);
`else
        return 8'h00;
`endif
    endfunction

    task automatic check_frame(input string tag, input logic [9:0] x, input logic [9:0] y,
                               input logic [2:0] b, input int nbits);
        logic [0:79] exp_bits;
        logic [7:0]  bt;
        logic [10:0] ent;
        int          nfull;
        nfull    = nbits / 8;
        exp_bits = '0;
        for (int i = 0; i < nbits; i++) begin
            bt          = model_byte(x, y, b, i / 8);
            exp_bits[i] = bt[7 - (i % 8)];
        end
        check({tag, " miso"}, miso_bits, exp_bits);
        check({tag, " cmd_count"}, cmd_q.size(), nfull);
        for (int k = 0; k < nfull && k < cmd_q.size(); k++) begin
            ent = {(k > 7) ? 3'd7 : 3'(k), mosi_bits[8*k +: 8]};
            check($sformatf("%s cmd%0d", tag, k), cmd_q[k], ent);
        end
        check({tag, " frame_done"}, done_seen, ((nbits % 8 == 0) && (nfull >= 1)) ? 1 : 0);
        check({tag, " frame_err"}, err_seen, (nbits % 8 != 0) ? 1 : 0);
        if (nbits % 8 != 0) exp_errs++;
        check({tag, " err_cnt"}, err_cnt, exp_err_cnt());
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
        int          nbits;
        logic [7:0]  first_mosi;
        logic [63:0] exp_miso;
        int          exp_cmds;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{10'h2A5, 10'h13C, 3'b101, 40, 8'hC0, 64'hA5023C0105000000, 5, 1'b1, 1'b0};
        vecs[1] = '{10'h3FF, 10'h3FF, 3'b111, 56, 8'h5A, 64'hFF03FF0307000000, 7, 1'b1, 1'b0};
        vecs[2] = '{10'h000, 10'h000, 3'b000, 13, 8'hFF, 64'h0000000000000000, 1, 1'b0, 1'b1};
        vecs[3] = '{10'h155, 10'h2AA, 3'b010, 13, 8'h81, 64'h5500000000000000, 1, 1'b0, 1'b1};
        vecs[4] = '{10'h0F0, 10'h30F, 3'b011,  8, 8'h3C, 64'hF000000000000000, 1, 1'b1, 1'b0};
        vecs[5] = '{10'h123, 10'h234, 3'b110, 16, 8'h96, 64'h2301000000000000, 2, 1'b1, 1'b0};

        rst          = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.spi_mosi = 1'b0;
        x_val        = '0;
        y_val        = '0;
        buttons      = '0;
        watch_miso   = 1'b0;
        begin_frame();
        wait_clk(4);
        check("reset outputs", {bus.spi_miso, cmd_byte, cmd_valid, byte_idx, frame_done, frame_err, err_cnt}, '0);
        rst = 1'b0;
        wait_clk(8);

        for (int v = 0; v < 6; v++) begin
            x_val     = vecs[v].x;
            y_val     = vecs[v].y;
            buttons   = vecs[v].btn;
            mosi_bits = '0;
            mosi_bits[0:7] = vecs[v].first_mosi;
            begin_frame();
            do_frame(vecs[v].nbits);
            check($sformatf("vec%0d miso", v), miso_bits[0:63], vecs[v].exp_miso);
            check($sformatf("vec%0d cmd_count", v), cmd_q.size(), vecs[v].exp_cmds);
            if (cmd_q.size() > 0) begin
                check($sformatf("vec%0d first_cmd", v), cmd_q[0][7:0], vecs[v].first_mosi);
                check($sformatf("vec%0d last_idx", v), cmd_q[$][10:8], vecs[v].exp_cmds - 1);
            end
            check($sformatf("vec%0d frame_done", v), done_seen, vecs[v].exp_done);
            check($sformatf("vec%0d frame_err", v), err_seen, vecs[v].exp_err);
            if (vecs[v].exp_err) exp_errs++;
            check($sformatf("vec%0d err_cnt", v), err_cnt, exp_err_cnt());
        end

        // Inputs change mid-frame; the frame keeps the CS-fall snapshot, the next one sees the new X.
        x_val     = 10'h2A5;
        y_val     = 10'h13C;
        buttons   = 3'b101;
        mosi_bits = {$urandom, $urandom, 16'($urandom)};
        begin_frame();
        fork
            do_frame(40);
            begin
                wait_clk(100);
                x_val = 10'h3FF;
            end
        join
        check_frame("snap", 10'h2A5, 10'h13C, 3'b101, 40);
        begin_frame();
        do_frame(16);
        check_frame("snap_next", 10'h3FF, 10'h13C, 3'b101, 16);

        // Reset during byte 2 with CS held low: stay silent until CS cycles.
        mosi_bits = {$urandom, $urandom, 16'($urandom)};
        x_val     = 10'h1E7;
        begin_frame();
        bus.spi_cs   = 1'b0;
        bus.spi_mosi = mosi_bits[0];
        wait_clk(8);
        for (int i = 0; i < 20; i++) begin
            bus.spi_sck = 1'b1;
            wait_clk(8);
            bus.spi_sck  = 1'b0;
            bus.spi_mosi = mosi_bits[i+1];
            wait_clk(8);
        end
        rst = 1'b1;
        wait_clk(1);
        check("mid-frame reset outputs",
              {bus.spi_miso, cmd_byte, cmd_valid, byte_idx, frame_done, frame_err, err_cnt}, '0);
        rst      = 1'b0;
        exp_errs = 0;
        begin_frame();
        watch_miso = 1'b1;
        for (int i = 20; i < 40; i++) begin
            bus.spi_sck = 1'b1;
            wait_clk(8);
            bus.spi_sck  = 1'b0;
            bus.spi_mosi = mosi_bits[i+1];
            wait_clk(8);
        end
        bus.spi_cs = 1'b1;
        wait_clk(12);
        watch_miso = 1'b0;
        check("reset rest miso", miso_hit, 1'b0);
        check("reset rest cmd_count", cmd_q.size(), 0);
        check("reset rest pulses", {done_seen[7:0], err_seen[7:0]}, 16'h0);
        mosi_bits = {$urandom, $urandom, 16'($urandom)};
        begin_frame();
        do_frame(40);
        check_frame("after_reset", 10'h1E7, y_val, buttons, 40);

        // SCK/MOSI activity with CS high must be ignored.
        begin_frame();
        watch_miso = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus.spi_sck  = 1'($urandom);
            bus.spi_mosi = 1'($urandom);
            wait_clk($urandom_range(1, 6));
        end
        bus.spi_sck = 1'b0;
        wait_clk(8);
        watch_miso = 1'b0;
        check("idle noise miso", miso_hit, 1'b0);
        check("idle noise cmd_count", cmd_q.size(), 0);
        check("idle noise pulses", {done_seen[7:0], err_seen[7:0]}, 16'h0);

        for (int f = 0; f < 16; f++) begin
            int         nb;
            logic [9:0] rx;
            logic [9:0] ry;
            logic [2:0] rb;
            nb        = (f == 0) ? 0 : $urandom_range(1, 80);
            rx        = 10'($urandom);
            ry        = 10'($urandom);
            rb        = 3'($urandom);
            x_val     = rx;
            y_val     = ry;
            buttons   = rb;
            mosi_bits = {$urandom, $urandom, 16'($urandom)};
            begin_frame();
            do_frame(nb);
            check_frame($sformatf("rand%0d", f), rx, ry, rb, nb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
